// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
// Field widths are derived from the cache parameters via constant functions.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        WRITE_MEM = 2'd2
    } state_t;

    function automatic int byte_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int offset_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int blocks_num);
        return $clog2(blocks_num);
    endfunction

    function automatic int tag_w(
        input int addr_width,
        input int data_width,
        input int words_per_block,
        input int blocks_num
    );
        return addr_width - byte_w(data_width)
             - offset_w(words_per_block) - index_w(blocks_num);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag, valid and data storage for a direct-mapped cache.
// Asynchronous lookup; synchronous whole-block or single-word writes.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCKS_NUM      = 4,
    parameter int TAG_W           = 26
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [index_w(BLOCKS_NUM)-1:0]        index,
    input  logic [offset_w(WORDS_PER_BLOCK)-1:0]  offset,
    output logic                                  line_valid,
    output logic [TAG_W-1:0]                      line_tag,
    output logic [DATA_WIDTH-1:0]                 line_word,
    input  logic                                  blk_we,
    input  logic [TAG_W-1:0]                      blk_tag,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] blk_data,
    input  logic                                  word_we,
    input  logic [DATA_WIDTH-1:0]                 word_data
);

    logic [BLOCKS_NUM-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [BLOCKS_NUM];
    logic [DATA_WIDTH-1:0] data_q [BLOCKS_NUM][WORDS_PER_BLOCK];

    // Reset has priority so a refill landing on the reset edge stays invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (blk_we) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (blk_we) begin
            tag_q[index] <= blk_tag;
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                data_q[index][w] <= blk_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (word_we) begin
            data_q[index][offset] <= word_data;
        end
    end

    assign line_valid = valid_q[index];
    assign line_tag   = tag_q[index];
    assign line_word  = data_q[index][offset];

endmodule

// File: rtl/cache_wt_fsm_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Stalls the CPU across block refills and word write-throughs to memory.
module cache_wt_fsm_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCKS_NUM      = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cpu_read,
    input  logic                                  cpu_write,
    input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
    input  logic [DATA_WIDTH-1:0]                 cpu_wdata,
    output logic [DATA_WIDTH-1:0]                 cpu_rdata,
    output logic                                  cpu_stall,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
    input  logic                                  mem_ready,
    output logic [CNT_WIDTH-1:0]                  hit_count,
    output logic [CNT_WIDTH-1:0]                  miss_count
);

    localparam int BYTE_W = byte_w(DATA_WIDTH);
    localparam int OFF_W  = offset_w(WORDS_PER_BLOCK);
    localparam int IDX_W  = index_w(BLOCKS_NUM);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_BLOCK, BLOCKS_NUM);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
        ADDR_WIDTH'((1 << (OFF_W + BYTE_W)) - 1);

    logic [TAG_W-1:0]      tag;
    logic [IDX_W-1:0]      index;
    logic [OFF_W-1:0]      offset;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_word;
    logic                  hit;

    state_t state_q;
    state_t state_d;
    logic   post_refill_q;

    logic hit_inc;
    logic miss_inc;
    logic start_refill;
    logic start_write;
    logic blk_we;
    logic word_we;

    assign tag    = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign index  = cpu_addr[BYTE_W+OFF_W +: IDX_W];
    assign offset = cpu_addr[BYTE_W +: OFF_W];

    cache_line_array #(
        .DATA_WIDTH      (DATA_WIDTH),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .BLOCKS_NUM      (BLOCKS_NUM),
        .TAG_W           (TAG_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .index      (index),
        .offset     (offset),
        .line_valid (line_valid),
        .line_tag   (line_tag),
        .line_word  (line_word),
        .blk_we     (blk_we),
        .blk_tag    (tag),
        .blk_data   (mem_rdata),
        .word_we    (word_we),
        .word_data  (cpu_wdata)
    );

    assign hit       = line_valid && (line_tag == tag);
    assign cpu_rdata = hit ? line_word : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_stall    = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        start_refill = 1'b0;
        start_write  = 1'b0;
        blk_we       = 1'b0;
        word_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    cpu_stall   = 1'b1;
                    word_we     = hit;
                    start_write = 1'b1;
                    state_d     = WRITE_MEM;
                end else if (cpu_read) begin
                    if (hit) begin
                        // The lookup right after a refill is the same access.
                        hit_inc = !post_refill_q;
                    end else begin
                        cpu_stall    = 1'b1;
                        miss_inc     = 1'b1;
                        start_refill = 1'b1;
                        state_d      = REFILL;
                    end
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    blk_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE_MEM: begin
                cpu_stall = !mem_ready;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            post_refill_q <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            if (blk_we) begin
                post_refill_q <= 1'b1;
            end else if (state_q == IDLE) begin
                post_refill_q <= 1'b0;
            end
            if (hit_inc) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (miss_inc) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    // Memory port is registered so it holds steady for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start_refill) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr & ~LOW_MASK;
        end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else if (mem_ready && state_q != IDLE) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_wt_fsm_ctrl.sv
// Scoreboard bench for cache_wt_fsm_ctrl with a fixed-latency block memory.
// Stimulus queues expected CPU and memory responses; a monitor checks them.
module tb_cache_wt_fsm_ctrl;

    localparam int LAT = 3;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        int          stall;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] mem_words [128];
    bit          mem_hold;
    int          n_checks;
    int          n_fail;
    int          stall_cnt;
    int          mem_cnt;

    cache_wt_fsm_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: ready pulses on the (LAT+1)-th cycle of a request.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_cnt   = 0;
        for (int i = 0; i < 128; i++) begin
            mem_words[i] = 32'h1000_0000 + i;
        end
        mem_words[4] = 32'd1;
        mem_words[5] = 32'd2;
        mem_words[6] = 32'd3;
        mem_words[7] = 32'd4;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_req && !mem_hold) begin
                mem_cnt++;
                if (mem_cnt == LAT + 1) begin
                    mem_cnt   = 0;
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_words[mem_addr[8:2]] = mem_wdata;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            mem_rdata[i*32 +: 32] = mem_words[mem_addr[8:2] + 7'(i)];
                        end
                    end
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Monitor: pops on CPU acceptance and on memory-port activity.
    always @(negedge clk) begin
        cpu_exp_t ce;
        mem_exp_t me;
        if (reset || !(cpu_read || cpu_write)) begin
            stall_cnt = 0;
        end else if (cpu_stall) begin
            stall_cnt++;
        end else if (cpu_q.size() == 0) begin
            check("cpu_unexpected_accept", 32'd1, 32'd0);
        end else begin
            ce = cpu_q.pop_front();
            check("stall_cycles", 32'(stall_cnt), 32'(ce.stall));
            if (!ce.wr) begin
                check("cpu_rdata", cpu_rdata, ce.rdata);
            end
            stall_cnt = 0;
        end
        if (!reset && mem_req) begin
            if (mem_q.size() == 0) begin
                check("mem_unexpected_req", 32'd1, 32'd0);
            end else begin
                me = mem_q[0];
                check("mem_we", 32'(mem_we), 32'(me.we));
                check("mem_addr", mem_addr, me.addr);
                if (me.we) begin
                    check("mem_wdata", mem_wdata, me.wdata);
                end
                if (mem_ready) begin
                    void'(mem_q.pop_front());
                end
            end
        end
    end

    task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input int exp_stall, input bit exp_mem);
        bit done;
        cpu_q.push_back('{wr, exp_rd, exp_stall});
        if (exp_mem) begin
            mem_q.push_back('{wr, wr ? a : (a & ~32'hF), wd});
        end
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check("op_timeout", a, 32'hFFFF_FFFF);
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic counters(input int h, input int m);
        check("hit_count", hit_count, 32'(h));
        check("miss_count", miss_count, 32'(m));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stall_cnt = 0;
        mem_hold  = 1'b0;
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(cpu_stall), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_rdata", cpu_rdata, 32'd0);
        counters(0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        op(1, 0, 32'h10, 0, 32'd1, 5, 1);
        counters(0, 1);
        op(1, 0, 32'h14, 0, 32'd2, 0, 0);
        counters(1, 1);
        op(1, 0, 32'h50, 0, 32'h1000_0014, 5, 1);
        counters(1, 2);
        op(1, 0, 32'h14, 0, 32'd2, 5, 1);
        counters(1, 3);

        op(0, 1, 32'h18, 32'hDEAD_BEEF, 0, 4, 1);
        counters(1, 3);
        op(1, 0, 32'h18, 0, 32'hDEAD_BEEF, 0, 0);
        counters(2, 3);

        op(0, 1, 32'h100, 32'h1234_5678, 0, 4, 1);
        counters(2, 3);
        op(1, 0, 32'h100, 0, 32'h1234_5678, 5, 1);
        counters(2, 4);
        op(1, 0, 32'h104, 0, 32'h1000_0041, 0, 0);
        counters(3, 4);

        op(1, 1, 32'h104, 32'hCAFE_F00D, 0, 4, 1);
        counters(3, 4);
        op(1, 0, 32'h104, 0, 32'hCAFE_F00D, 0, 0);
        counters(4, 4);

        // Reset lands while a refill is still waiting on memory.
        mem_hold = 1'b1;
        mem_q.push_back('{1'b0, 32'h20, 32'h0});
        cpu_read = 1'b1;
        cpu_addr = 32'h20;
        repeat (4) @(posedge clk);
        #1;
        check("refill_mem_req", 32'(mem_req), 32'd1);
        check("refill_stall", 32'(cpu_stall), 32'd1);
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        counters(0, 0);
        reset    = 1'b0;
        mem_hold = 1'b0;
        mem_q.delete();
        @(posedge clk);
        #1;
        op(1, 0, 32'h20, 0, 32'h1000_0008, 5, 1);
        counters(0, 1);

        repeat (3) @(posedge clk);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
